pulse_width_meter: RTL and testbench
====================================

# pulse_width_meter

Measures how long an input level stays high, in enabled clock cycles, and hands the result downstream over a valid/ready handshake. `regCiclos` turns a run of enabled cycles into a done flag. This block does the reverse: it turns an observed pulse back into a cycle count. It sits beside the cycle counters in the timing path and uses the same `enable` tick convention, so a shared prescaler can drive both.

## Interface
Parameters:
- `WIDTH`, default 4: width of the measured count; maximum representable value is 2^WIDTH-1.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `enable`, in, 1: count tick. A cycle is counted only when `enable`=1.
- `pulse_in`, in, 1: level to measure. It is synchronous to `clk`; synchronizing it is the caller's job.
- `out_valid`, out, 1: a measurement result is available.
- `out_ready`, in, 1: the consumer accepts the result.
- `count`, out, WIDTH: measured width; stable while `out_valid`=1.
- `overflow`, out, 1: the measured width exceeded 2^WIDTH-1; stable while `out_valid`=1.
- `busy`, out, 1: 1 in MEASURE or HOLD.
- `dropped`, out, 1: sticky flag, set when a pulse start is ignored; cleared only by reset.

## Operation
- Internal `prev` register holds `pulse_in` from the previous edge. A rising edge is `pulse_in`=1 && `prev`=0.
- FSM states:
  - IDLE: on a rising edge, go to MEASURE. Set `cnt` = `enable` ? 1 : 0 and clear the overflow bit.
  - MEASURE:
    - While `pulse_in`=1 and `enable`=1, add 1 to `cnt`.
    - While `pulse_in`=1 and `enable`=0, hold `cnt`.
    - First edge with `pulse_in`=0: load `count` <= `cnt`, `overflow` <= overflow bit, `out_valid` <= 1, go to HOLD.
  - HOLD:
    - On an edge with `out_valid`=1 && `out_ready`=1, the result transfers. `out_valid` <= 0, go to IDLE.
    - A rising edge seen in HOLD (including the acceptance cycle) is ignored and sets `dropped`.
    - A pulse whose rising edge is missed is never partially measured: IDLE only leaves on a rising edge.
- Increment at `cnt`=2^WIDTH-1 sets the overflow bit. Whether `cnt` wraps or saturates is set under Configuration.
- `count` and `overflow` change only on the MEASURE->HOLD transition.

## Timing
- Reset values:
  - `out_valid`=0, `count`=0, `overflow`=0, `busy`=0, `dropped`=0.
  - State is IDLE, `prev`=0, `cnt`=0.
- Pulse sampled high on N consecutive edges with `enable`=1 throughout gives `count`=N (N <= 2^WIDTH-1).
- `out_valid` rises after the first edge that samples `pulse_in`=0, i.e. 1 cycle after the pulse falls.
- `busy` rises the cycle after the edge that detects the rising edge.
- Handshake:
  - `out_valid` never drops without a transfer.
  - `out_ready` may be high before `out_valid`.
  - Minimum 1 cycle in HOLD.
- Fastest back-to-back: the next rising edge is detectable in the cycle after the transfer edge.
- Reset asserted mid-MEASURE or mid-HOLD discards the measurement and any pending result; `out_valid` goes to 0 asynchronously.
- `enable`=0 for the whole pulse gives `count`=0, `overflow`=0, and a result is still produced.

## Configuration
- `PULSE_WIDTH_METER_SAT_EN` defined: `cnt` saturates at 2^WIDTH-1. An overlong pulse reports `count`=2^WIDTH-1 with `overflow`=1.
- Not defined: `cnt` wraps modulo 2^WIDTH. `overflow`=1 and `count` = width mod 2^WIDTH.
- The overflow flag sets identically in both builds.

## Test plan
- WIDTH=4, `enable`=1, 5-cycle pulse, `out_ready`=1 -> `count`=5, `overflow`=0, `out_valid` high 1 cycle, 1 cycle after the fall.
- WIDTH=4, 15-cycle pulse -> `count`=15, `overflow`=0.
- WIDTH=4, 20-cycle pulse:
  - Without SAT_EN -> `count`=4, `overflow`=1.
  - With SAT_EN -> `count`=15, `overflow`=1.
- `enable` toggling every cycle during an 8-cycle pulse, starting high -> `count`=4.
- `out_ready`=0, 3-cycle pulse then 6-cycle pulse -> `count`=3 held, `dropped`=1. After `out_ready`=1 the transfer occurs and no result of 6 appears.
- Reset low in the middle of a 10-cycle pulse, released while `pulse_in` is still high -> all outputs 0 and no result until the next full pulse. A following 2-cycle pulse gives `count`=2.

Source files
------------

// File: rtl/pulse_width_meter.sv
// Measures how many enabled cycles a synchronous level stays high and returns the count over valid/ready.
// Build option: define PULSE_WIDTH_METER_SAT_EN to saturate the count instead of wrapping it.
module pulse_width_meter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             busy,
  output logic             dropped
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic             prev_q, prev_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;
  logic             rise_s;

  // Next-state and datapath logic for the measurement FSM.
  always_comb begin
    state_d     = state_q;
    prev_d      = pulse_in;
    // A rise only counts once a genuine low has been sampled, so a pulse already
    // high when reset is released is never partially measured.
    armed_d     = armed_q | ~pulse_in;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    dropped_d   = dropped_q;
    rise_s      = pulse_in & ~prev_q & armed_q;

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = MEASURE;
          cnt_d   = enable ? CNT_ONE : CNT_ZERO;
          ovf_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (pulse_in) begin
          if (enable) begin
            if (cnt_q == CNT_MAX) begin
              ovf_d = 1'b1;
`ifdef PULSE_WIDTH_METER_SAT_EN
              cnt_d = CNT_MAX;
`else
              cnt_d = CNT_ZERO;
`endif
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          count_d     = cnt_q;
          overflow_d  = ovf_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (rise_s) begin
          dropped_d = 1'b1;
        end else begin
          dropped_d = dropped_q;
        end
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prev_q      <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= CNT_ZERO;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= CNT_ZERO;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
    end
  end

  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: stimulus pushes expected results, a monitor pops them on each transfer.
module tb_pulse_width_meter;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         pulse_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] count;
  logic         overflow;
  logic         busy;
  logic         dropped;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  pulse_width_meter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .pulse_in (pulse_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic push(input int c, input bit o);
    exp_t e;
    e.c = c[W-1:0];
    e.o = o;
    exp_q.push_back(e);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high now.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", exp_q.size(), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_count", int'(count), int'(e.c));
        check("result_overflow", int'(overflow), int'(e.o));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  // mode 0: enable high, 1: enable toggles starting high, 2: enable low.
  task automatic drive_pulse(input int len, input int mode);
    for (int i = 0; i < len; i++) begin
      enable   = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : 1'b0;
      pulse_in = 1'b1;
      tick();
    end
    pulse_in = 1'b0;
    enable   = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    gap(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    enable    = 1'b1;
    pulse_in  = 1'b0;
    out_ready = 1'b1;
    gap(3);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_count", int'(count), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_dropped", int'(dropped), 0);
    rst = 1'b1;
    gap(2);

    // 5-cycle pulse: valid one cycle after the fall, for exactly one cycle.
    push(5, 1'b0);
    drive_pulse(5, 0);
    check("t1_busy_measuring", int'(busy), 1);
    check("t1_valid_before", int'(out_valid), 0);
    tick();
    check("t1_valid_rise", int'(out_valid), 1);
    tick();
    check("t1_valid_one_cycle", int'(out_valid), 0);
    drain("t1_drain");

    push(15, 1'b0);
    drive_pulse(15, 0);
    drain("t2_drain");

`ifdef PULSE_WIDTH_METER_SAT_EN
    push(15, 1'b1);
`else
    push(4, 1'b1);
`endif
    drive_pulse(20, 0);
    drain("t3_drain");

    push(4, 1'b0);
    drive_pulse(8, 1);
    drain("t4_drain");

    push(0, 1'b0);
    drive_pulse(3, 2);
    drain("t5_drain");

    // Stalled consumer: second pulse starts in HOLD and must be dropped.
    out_ready = 1'b0;
    push(3, 1'b0);
    drive_pulse(3, 0);
    gap(3);
    check("t6_held_valid", int'(out_valid), 1);
    check("t6_held_count", int'(count), 3);
    pulse_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) out_ready = 1'b1;
      tick();
    end
    pulse_in = 1'b0;
    check("t6_dropped", int'(dropped), 1);
    gap(10);
    check("t6_no_late_result", exp_q.size(), 0);

    // Reset in the middle of a 10-cycle pulse, released while still high.
    pulse_in = 1'b1;
    gap(4);
    rst = 1'b0;
    #1;
    check("t7_rst_valid", int'(out_valid), 0);
    check("t7_rst_busy", int'(busy), 0);
    check("t7_rst_count", int'(count), 0);
    check("t7_rst_overflow", int'(overflow), 0);
    check("t7_rst_dropped", int'(dropped), 0);
    tick();
    rst = 1'b1;
    gap(4);
    pulse_in = 1'b0;
    gap(5);
    check("t7_no_partial_valid", int'(out_valid), 0);
    check("t7_no_partial_busy", int'(busy), 0);
    push(2, 1'b0);
    drive_pulse(2, 0);
    drain("t7_drain");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
